// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared segment codes and travel-direction encodings for the floor display
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_RSVD = 2'b11
  } dir_e;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;
  localparam logic [6:0] SEG_UP    = 7'b1111110;
  localparam logic [6:0] SEG_DOWN  = 7'b1110111;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low seven-segment code
module seg7_decode
  import elevator_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (digit)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/floor_display_scan.sv
// rtl/floor_display_scan.sv - multiplexed floor/direction display with door blink and lamp test
module floor_display_scan
  import elevator_pkg::*;
#(
  parameter int N_FLOORS  = 6,
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000,
  localparam int FLOOR_W  = $clog2(N_FLOORS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FLOOR_W-1:0]        now,
  input  logic [1:0]                dir,
  input  logic                      door_open,
  input  logic                      lamp_test,
  input  logic [N_FLOORS-1:0]       input_in,
  input  logic [2*(N_FLOORS-1)-1:0] input_out,
  output logic [6:0]                seg_n,
  output logic [N_DIGITS-1:0]       an_n,
  output logic [N_FLOORS-1:0]       output_in,
  output logic [2*(N_FLOORS-1)-1:0] output_out,
  output logic [FLOOR_W-1:0]        onow
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int IDX_W   = $clog2(N_DIGITS);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               scan_wrap;
  logic               blink_wrap;

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_wrap) blink_phase <= ~blink_phase;
      if (scan_wrap)
        digit_idx <= (digit_idx == IDX_W'(N_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end
  end

  logic [6:0] now_ext;
  logic [3:0] units, tens, dec_digit;
  logic [6:0] dec_seg;
  logic       floor_bad;
  dir_e       dir_s;

  assign now_ext   = 7'(now);
  assign units     = 4'(now_ext % 7'd10);
  assign tens      = 4'(now_ext / 7'd10);
  assign floor_bad = (now > FLOOR_W'(N_FLOORS));
  assign dir_s     = dir_e'(dir);
  assign dec_digit = (digit_idx == IDX_W'(0)) ? units : tens;

  seg7_decode u_seg7_decode (
    .digit (dec_digit),
    .seg_n (dec_seg)
  );

  logic [6:0]          seg_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  // Slot count 0 is the anti-ghost blank: anodes off and segments dark together.
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = '1;
    if (scan_cnt != '0) begin
      an_nxt[digit_idx] = 1'b0;
      if (digit_idx == IDX_W'(0) || digit_idx == IDX_W'(1)) begin
        if (door_open && blink_phase)                 seg_nxt = SEG_BLANK;
        else if (floor_bad)                           seg_nxt = SEG_DASH;
        else if (digit_idx == IDX_W'(1) && tens == 4'd0) seg_nxt = SEG_BLANK;
        else                                          seg_nxt = dec_seg;
      end else if (digit_idx == IDX_W'(2)) begin
        case (dir_s)
          DIR_UP:   seg_nxt = SEG_UP;
          DIR_DOWN: seg_nxt = SEG_DOWN;
          default:  seg_nxt = SEG_BLANK;
        endcase
      end
    end
    if (lamp_test) seg_nxt = SEG_ALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= SEG_BLANK;
      an_n       <= '1;
      output_in  <= '0;
      output_out <= '0;
      onow       <= '0;
    end else begin
      seg_n      <= seg_nxt;
      an_n       <= an_nxt;
      output_in  <= lamp_test ? '1 : input_in;
      output_out <= lamp_test ? '1 : input_out;
      onow       <= now;
    end
  end

endmodule

// File: doc/floor_display_scan.md
FLOOR_DISPLAY_SCAN -- requirements
Module: floor_display_scan

Interface
REQ-001 Parameter N_FLOORS, default 6: number of floors, legal range 2..99.
REQ-002 Parameter N_DIGITS, default 4: scanned digit count, legal range 3..8.
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-004 Parameter BLINK_DIV, default 12500000: clk cycles per blink half-period, minimum 2.
REQ-005 Derived constant FLOOR_W = clog2(N_FLOORS+1).
REQ-006 clk  in  1: the single clock, rising edge.
REQ-007 rst_n  in  1: asynchronous, active-low reset.
REQ-008 now  in  FLOOR_W: current floor.
REQ-009 dir  in  2: travel direction, 00 idle, 01 up, 10 down, 11 treated as idle.
REQ-010 door_open  in  1: door-open status.
REQ-011 lamp_test  in  1: forces all indicators on.
REQ-012 input_in  in  N_FLOORS: cabin request flags.
REQ-013 input_out  in  2*(N_FLOORS-1): hall up/down request flags.
REQ-014 seg_n  out  7: active-low segments, bit order gfedcba.
REQ-015 an_n  out  N_DIGITS: active-low digit enables.
REQ-016 output_in  out  N_FLOORS: registered copy of input_in.
REQ-017 output_out  out  2*(N_FLOORS-1): registered copy of input_out.
REQ-018 onow  out  FLOOR_W: registered copy of now.

Function
REQ-019 All outputs SHALL be registered; output_in, output_out and onow SHALL follow their inputs with exactly 1 cycle of latency.
REQ-020 A scan counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance and wrap from N_DIGITS-1 to 0.
REQ-021 During the first cycle of each digit slot, an_n SHALL be all ones as an anti-ghost blank; for the rest of the slot, only bit[index] SHALL be low.
REQ-022 Digit 0 SHALL show the floor units and digit 1 the floor tens; tens SHALL be blank when the floor is below 10.
REQ-023 A now value greater than N_FLOORS SHALL show dash (0111111) on digits 0 and 1.
REQ-024 Digit 2 SHALL show up as 1111110 (segment a), down as 1110111 (segment d), and idle as blank (1111111).
REQ-025 Digits 3 and above SHALL be blank.
REQ-026 A blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; while door_open=1 and blink_phase=1, digits 0 and 1 SHALL be blank.
REQ-027 Blink SHALL have no effect when door_open=0; blink_phase SHALL continue free-running.
REQ-028 While lamp_test=1, seg_n SHALL be 0000000 and output_in and output_out SHALL be all ones; scanning SHALL continue, and an_n and onow SHALL be unaffected.
REQ-029 The digit-to-segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-030 seg_n and an_n SHALL change together on the same edge.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously clear the scan counter, digit index, blink counter and blink_phase to 0.
REQ-032 On rst_n low, the block SHALL set an_n to all ones, seg_n to 1111111, output_in and output_out to 0, and onow to 0.
REQ-033 Reset deasserted mid-scan SHALL restart at digit 0, with the blank cycle first.

Structure
REQ-034 Segment code constants, dash, blank and the dir encodings SHALL live in the shared package elevator_pkg.
REQ-035 Digit decoding SHALL be a combinational sub-module seg7_decode (4-bit digit in, 7-bit seg_n out).

Verification
REQ-036 Run with SCAN_DIV=4 and BLINK_DIV=8 in all scenarios.
REQ-037 Reset release -> an_n=1111 for 1 cycle, then 1110 for 3 cycles, then 1111, then 1101.
REQ-038 now=3, dir=01, door_open=0 -> digit0 seg_n=0110000, digit1 blank, digit2 1111110.
REQ-039 N_FLOORS=12, now=11 -> digit0 and digit1 both 1111001; now=13 -> both 0111111.
REQ-040 door_open=1, now=5 -> digit0 alternates 0010010 and blank every 8 cycles.
REQ-041 lamp_test=1, input_in=0 -> seg_n=0000000 and output_in=111111 on the next cycle.
REQ-042 input_out=1010101010 -> output_out equals it one cycle later; asserting rst_n low mid-cycle -> immediate clear.
